// File: rtl/dca_matrix_seq_pkg.sv
// rtl/dca_matrix_seq_pkg.sv - shared op/state encodings and row-counter width for the matrix register sequencer
package dca_matrix_seq_pkg;

    // Matrix dimension of the default type-1 register configuration.
    localparam int DCA_MSEQ_MATRIX_NUM_ROW = 8;

    typedef enum logic [1:0] {
        DCA_MSEQ_OP_LOAD             = 2'd0,
        DCA_MSEQ_OP_STORE            = 2'd1,
        DCA_MSEQ_OP_LOAD_XPOSE_STORE = 2'd2,
        DCA_MSEQ_OP_XPOSE            = 2'd3
    } dca_mseq_op_e;

    typedef enum logic [2:0] {
        DCA_MSEQ_ST_IDLE  = 3'd0,
        DCA_MSEQ_ST_INIT  = 3'd1,
        DCA_MSEQ_ST_LOAD  = 3'd2,
        DCA_MSEQ_ST_PAD   = 3'd3,
        DCA_MSEQ_ST_XPOSE = 3'd4,
        DCA_MSEQ_ST_DRAIN = 3'd5,
        DCA_MSEQ_ST_DONE  = 3'd6
    } dca_mseq_state_e;

    // Counter must hold the value N itself, hence N+1 codes.
    function automatic int row_cnt_bw(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int BW_ROW_CNT = row_cnt_bw(DCA_MSEQ_MATRIX_NUM_ROW);

endpackage

// File: rtl/dca_matrix_seq_row_counter.sv
// rtl/dca_matrix_seq_row_counter.sv - clear/increment row counter with terminal-count flag
module dca_matrix_seq_row_counter #(
    parameter int BW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [BW-1:0] limit,
    output logic [BW-1:0] cnt,
    output logic          last
);

    logic [BW-1:0] cnt_q;
    logic [BW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    // True while the row being handled now is the final one before limit.
    assign last = ((cnt_q + BW'(1)) == limit);

endmodule

// File: rtl/dca_matrix_register_sequencer.sv
// rtl/dca_matrix_register_sequencer.sv - command sequencer for DCA matrix register load/transpose/drain, optional DCA_MATRIX_SEQ_ZERO_PAD_EN
module dca_matrix_register_sequencer
    import dca_matrix_seq_pkg::*;
#(
    parameter  int MATRIX_SIZE_PARA = 8,
    parameter  int BW_TENSOR_SCALAR = 32,
    localparam int BW_TENSOR_ROW    = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR,
    localparam int BW_ROW_CNT_L     = row_cnt_bw(MATRIX_SIZE_PARA)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [BW_ROW_CNT_L-1:0]  cmd_num_rows,
    input  logic                     cmd_init,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BW_TENSOR_ROW-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BW_TENSOR_ROW-1:0] out_data,
    output logic                     reg_init,
    output logic                     reg_move_wenable,
    output logic [BW_TENSOR_ROW-1:0] reg_move_wdata_list,
    output logic                     reg_move_renable,
    input  logic [BW_TENSOR_ROW-1:0] reg_move_rdata_list,
    output logic                     reg_transpose,
    output logic                     busy,
    output logic                     done
);

    localparam logic [BW_ROW_CNT_L-1:0] N_CNT = BW_ROW_CNT_L'(MATRIX_SIZE_PARA);

    dca_mseq_state_e          state_q, state_d;
    dca_mseq_op_e             op_q, op_d;
    logic [BW_ROW_CNT_L-1:0]  num_rows_q, num_rows_d;
    logic [BW_ROW_CNT_L-1:0]  num_rows_cmd;
    logic [BW_ROW_CNT_L-1:0]  cnt_limit;
    logic [BW_ROW_CNT_L-1:0]  row_cnt;
    logic                     cnt_clr;
    logic                     cnt_inc;
    logic                     cnt_last;
    logic                     pad_needed;

`ifdef DCA_MATRIX_SEQ_ZERO_PAD_EN
    // Zero or out-of-range row counts fall back to a full matrix.
    assign num_rows_cmd = ((cmd_num_rows == '0) || (cmd_num_rows > N_CNT)) ? N_CNT : cmd_num_rows;
    assign pad_needed   = (num_rows_q != N_CNT);
`else
    logic unused_num_rows;
    assign unused_num_rows = ^cmd_num_rows;
    assign num_rows_cmd    = N_CNT;
    assign pad_needed      = 1'b0;
`endif

    // LOAD stops at the stream row count; PAD and DRAIN always run up to N.
    assign cnt_limit = (state_q == DCA_MSEQ_ST_LOAD) ? num_rows_q : N_CNT;
    assign cnt_inc   = ((state_q == DCA_MSEQ_ST_LOAD) && in_valid)
                     || (state_q == DCA_MSEQ_ST_PAD)
                     || ((state_q == DCA_MSEQ_ST_DRAIN) && out_ready);
    assign cnt_clr   = ((state_d == DCA_MSEQ_ST_LOAD)  && (state_q != DCA_MSEQ_ST_LOAD))
                     || ((state_d == DCA_MSEQ_ST_DRAIN) && (state_q != DCA_MSEQ_ST_DRAIN));

    dca_matrix_seq_row_counter #(
        .BW (BW_ROW_CNT_L)
    ) u_row_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .limit (cnt_limit),
        .cnt   (row_cnt),
        .last  (cnt_last)
    );

    always_comb begin
        state_d             = state_q;
        op_d                = op_q;
        num_rows_d          = num_rows_q;
        cmd_ready           = 1'b0;
        in_ready            = 1'b0;
        out_valid           = 1'b0;
        reg_init            = 1'b0;
        reg_move_wenable    = 1'b0;
        reg_move_wdata_list = '0;
        reg_move_renable    = 1'b0;
        reg_transpose       = 1'b0;
        done                = 1'b0;

        case (state_q)
            DCA_MSEQ_ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d       = dca_mseq_op_e'(cmd_op);
                    num_rows_d = num_rows_cmd;
                    case (dca_mseq_op_e'(cmd_op))
                        DCA_MSEQ_OP_STORE: state_d = DCA_MSEQ_ST_DRAIN;
                        DCA_MSEQ_OP_XPOSE: state_d = DCA_MSEQ_ST_XPOSE;
                        default:           state_d = cmd_init ? DCA_MSEQ_ST_INIT : DCA_MSEQ_ST_LOAD;
                    endcase
                end
            end
            DCA_MSEQ_ST_INIT: begin
                reg_init = 1'b1;
                state_d  = DCA_MSEQ_ST_LOAD;
            end
            DCA_MSEQ_ST_LOAD: begin
                in_ready            = 1'b1;
                reg_move_wenable    = in_valid;
                reg_move_wdata_list = in_data;
                if (in_valid && cnt_last) begin
                    if (pad_needed) begin
                        state_d = DCA_MSEQ_ST_PAD;
                    end else if (op_q == DCA_MSEQ_OP_LOAD_XPOSE_STORE) begin
                        state_d = DCA_MSEQ_ST_XPOSE;
                    end else begin
                        state_d = DCA_MSEQ_ST_DONE;
                    end
                end
            end
            DCA_MSEQ_ST_PAD: begin
                // Zero rows push the short stream up so it still ends at row 0.
                reg_move_wenable = 1'b1;
                if (cnt_last) begin
                    state_d = (op_q == DCA_MSEQ_OP_LOAD_XPOSE_STORE) ? DCA_MSEQ_ST_XPOSE : DCA_MSEQ_ST_DONE;
                end
            end
            DCA_MSEQ_ST_XPOSE: begin
                reg_transpose = 1'b1;
                state_d = (op_q == DCA_MSEQ_OP_LOAD_XPOSE_STORE) ? DCA_MSEQ_ST_DRAIN : DCA_MSEQ_ST_DONE;
            end
            DCA_MSEQ_ST_DRAIN: begin
                out_valid        = 1'b1;
                reg_move_renable = out_ready;
                if (out_ready && cnt_last) begin
                    state_d = DCA_MSEQ_ST_DONE;
                end
            end
            DCA_MSEQ_ST_DONE: begin
                done    = 1'b1;
                state_d = DCA_MSEQ_ST_IDLE;
            end
            default: begin
                state_d = DCA_MSEQ_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DCA_MSEQ_ST_IDLE;
            op_q       <= DCA_MSEQ_OP_LOAD;
            num_rows_q <= N_CNT;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            num_rows_q <= num_rows_d;
        end
    end

    assign out_data = reg_move_rdata_list;
    assign busy     = (state_q != DCA_MSEQ_ST_IDLE);

endmodule
